// File: rtl/matrix_key_scan.sv
// matrix_key_scan: 4x4 keypad scanner with active-low row drive, column
// synchronizer, full-map debounce and single-shot press events.
module matrix_key_scan #(
    parameter logic [15:0] SCAN_TIME      = 16'd50_000,
    parameter logic [3:0]  DEBOUNCE_SCANS = 4'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] key_map,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down
);
    typedef enum logic {RELEASED, PRESSED} state_t;

    logic [3:0]  col_m;
    logic [3:0]  col_s;
    logic [15:0] cnt;
    logic [1:0]  row_idx;
    logic [15:0] snap;
    logic [15:0] prev;
    logic [15:0] full;
    logic [3:0]  stable_cnt;
    logic [3:0]  stable_next;
    logic        wrap;
    logic        done;
    state_t      state;
    state_t      state_next;
    logic        fire;
    logic [3:0]  lowest;

    // Idle columns read high, so the synchronizer resets to all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_m <= 4'hF;
            col_s <= 4'hF;
        end else begin
            col_m <= col;
            col_s <= col_m;
        end
    end

    assign wrap = (cnt == SCAN_TIME - 16'd1);
    assign done = wrap && (row_idx == 2'd3);

    // Row output moves on the same edge as row_idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            row_idx <= '0;
            row     <= 4'b1110;
        end else if (wrap) begin
            cnt     <= '0;
            row_idx <= row_idx + 2'd1;
            row     <= ~(4'b0001 << (row_idx + 2'd1));
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    always_comb begin
        full = snap;
        full[{row_idx, 2'b00} +: 4] = ~col_s;
    end

    always_comb begin
        stable_next = '0;
        if (full == prev) begin
            if (stable_cnt >= DEBOUNCE_SCANS)
                stable_next = DEBOUNCE_SCANS;
            else
                stable_next = stable_cnt + 4'd1;
        end
    end

    // The completion compare uses full, which already holds the row 3 sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap       <= '0;
            prev       <= '0;
            stable_cnt <= '0;
            key_map    <= '0;
        end else if (wrap) begin
            snap <= full;
            if (done) begin
                prev       <= full;
                stable_cnt <= stable_next;
                if (stable_next == DEBOUNCE_SCANS)
                    key_map <= full;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RELEASED;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RELEASED: if (key_map != 16'h0) state_next = PRESSED;
            PRESSED:  if (key_map == 16'h0) state_next = RELEASED;
        endcase
    end

    always_comb begin
        fire     = (state == RELEASED) && (key_map != 16'h0);
        key_down = (state == PRESSED);
        lowest   = '0;
        for (int i = 15; i >= 0; i--)
            if (key_map[i]) lowest = i[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= fire;
            if (fire)
                key_code <= lowest;
        end
    end
endmodule

// File: tb/tb_matrix_key_scan.sv
// tb_matrix_key_scan: directed bench for the keypad scanner with a
// behavioural keypad model and hand-computed scan timing.
module tb_matrix_key_scan;
    logic        clk;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key_map;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;

    logic [15:0] keys;
    int          errors;
    int          checks;
    int          pulses;
    int          p0;
    int          phase;

    matrix_key_scan #(
        .SCAN_TIME(16'd8),
        .DEBOUNCE_SCANS(4'd2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .col(col),
        .row(row),
        .key_map(key_map),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_down(key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row[r])
                for (int c = 0; c < 4; c++)
                    if (keys[r*4+c]) col[c] = 1'b0;
    end

    always @(posedge clk)
        if (key_valid) pulses <= pulses + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            phase = (phase + 1) % 32;
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_scan_start();
        while (phase != 0) tick(1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        pulses = 0;
        phase  = 0;
        keys   = 16'h0;
        rst    = 1'b1;
        tick(3);
        check("rst_row", 32'(row), 32'hE);
        check("rst_map", 32'(key_map), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_down", 32'(key_down), 32'h0);
        rst   = 1'b0;
        phase = 0;

        tick(7);
        check("row0_hold", 32'(row), 32'hE);
        tick(1);
        check("row1", 32'(row), 32'hD);
        tick(8);
        check("row2", 32'(row), 32'hB);
        tick(8);
        check("row3", 32'(row), 32'h7);
        tick(8);
        check("row0_again", 32'(row), 32'hE);

        p0   = pulses;
        keys = 16'h0040;
        tick(95);
        check("k6_map_early", 32'(key_map), 32'h0);
        tick(1);
        check("k6_map", 32'(key_map), 32'h0040);
        check("k6_valid_lat", 32'(key_valid), 32'h0);
        tick(1);
        check("k6_valid", 32'(key_valid), 32'h1);
        check("k6_code", 32'(key_code), 32'h6);
        check("k6_down", 32'(key_down), 32'h1);
        tick(1);
        check("k6_valid_end", 32'(key_valid), 32'h0);
        check("k6_down_hold", 32'(key_down), 32'h1);

        keys = 16'h0;
        tick(93);
        check("rel_map_early", 32'(key_map), 32'h0040);
        tick(1);
        check("rel_map", 32'(key_map), 32'h0);
        tick(1);
        check("rel_down", 32'(key_down), 32'h0);
        check("rel_valid", 32'(key_valid), 32'h0);
        check("k6_pulses", 32'(pulses - p0), 32'd1);

        to_scan_start();
        p0 = pulses;
        for (int k = 0; k < 10; k++) begin
            keys = (k % 2 == 0) ? 16'h0200 : 16'h0;
            tick(32);
        end
        check("bnc_map", 32'(key_map), 32'h0);
        check("bnc_pulses", 32'(pulses - p0), 32'd0);
        keys = 16'h0200;
        tick(95);
        check("k9_map_early", 32'(key_map), 32'h0);
        tick(1);
        check("k9_map", 32'(key_map), 32'h0200);
        tick(1);
        check("k9_valid", 32'(key_valid), 32'h1);
        check("k9_code", 32'(key_code), 32'h9);
        tick(1);
        check("k9_valid_end", 32'(key_valid), 32'h0);
        to_scan_start();
        check("k9_pulses", 32'(pulses - p0), 32'd1);

        keys = 16'h0;
        tick(96);
        check("k9_rel_map", 32'(key_map), 32'h0);
        tick(1);
        check("k9_rel_down", 32'(key_down), 32'h0);
        to_scan_start();

        p0   = pulses;
        keys = 16'h1008;
        tick(96);
        check("mk_map", 32'(key_map), 32'h1008);
        tick(1);
        check("mk_valid", 32'(key_valid), 32'h1);
        check("mk_code", 32'(key_code), 32'h3);
        check("mk_down", 32'(key_down), 32'h1);
        to_scan_start();
        check("mk_pulses", 32'(pulses - p0), 32'd1);

        p0   = pulses;
        keys = 16'h1009;
        tick(96);
        check("add_map", 32'(key_map), 32'h1009);
        tick(1);
        check("add_valid", 32'(key_valid), 32'h0);
        check("add_code", 32'(key_code), 32'h3);
        check("add_down", 32'(key_down), 32'h1);
        to_scan_start();
        check("add_pulses", 32'(pulses - p0), 32'd0);

        keys = 16'h0020;
        tick(96);
        check("k5_map", 32'(key_map), 32'h0020);
        tick(1);
        check("k5_code_held", 32'(key_code), 32'h3);
        check("k5_down", 32'(key_down), 32'h1);
        tick(4);

        rst = 1'b1;
        tick(1);
        check("mrst_row", 32'(row), 32'hE);
        check("mrst_map", 32'(key_map), 32'h0);
        check("mrst_code", 32'(key_code), 32'h0);
        check("mrst_valid", 32'(key_valid), 32'h0);
        check("mrst_down", 32'(key_down), 32'h0);
        tick(1);
        rst   = 1'b0;
        phase = 0;
        p0    = pulses;
        tick(95);
        check("rk5_map_early", 32'(key_map), 32'h0);
        tick(1);
        check("rk5_map", 32'(key_map), 32'h0020);
        tick(1);
        check("rk5_valid", 32'(key_valid), 32'h1);
        check("rk5_code", 32'(key_code), 32'h5);
        check("rk5_down", 32'(key_down), 32'h1);
        tick(1);
        check("rk5_valid_end", 32'(key_valid), 32'h0);
        check("rk5_pulses", 32'(pulses - p0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/matrix_key_scan.md
# matrix_key_scan

4x4 matrix keypad scanner: the input-side counterpart of the multiplexed seven-segment driver. Drives the keypad rows one at a time (active-low), samples the columns, debounces the full 16-key map, and emits a one-cycle event with the pressed key's code. It sits between the board keypad pins and the waveform-generator control logic, which consumes `key_valid`/`key_code`.

## Interface

- `SCAN_TIME`, 16'd50_000, clock cycles each row stays active (1 ms at 50 MHz); legal range ≥ 8.
- `DEBOUNCE_SCANS`, 4'd5, consecutive identical full-scan comparisons required before the key map is accepted; legal range 1..15.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `col` in 4: keypad columns, active-low (pulled up), asynchronous to `clk`.
- `row` out 4: keypad rows, active-low, exactly one row low at a time.
- `key_map` out 16: debounced map; bit `r*4+c` = 1 when key (row r, col c) is pressed.
- `key_code` out 4: code of the most recently accepted press (`r*4+c`).
- `key_valid` out 1: one-cycle pulse when a press is accepted.
- `key_down` out 1: level, high while any debounced key is pressed.

## Operation

- Synchronizer: `col` passes through 2 flip-flops (`col_s`) before any use.
- Dwell counter `cnt` (16 bit) counts 0..SCAN_TIME-1, then wraps; on wrap `row_idx` (2 bit) increments mod 4.
- `row` registered: `~(4'b0001 << row_idx)`; row 0 → 4'b1110, row 3 → 4'b0111.
- Sample: when `cnt == SCAN_TIME-1`, snapshot bits `[row_idx*4 +: 4] <= ~col_s`. Sampling at the end of the dwell guarantees ≥ 5 cycles of row settling plus synchronizer delay.
- Scan completion: the sample cycle with `row_idx == 3`. On completion (using the fully updated snapshot, including row 3):
  - snapshot == `prev`: `stable_cnt <= min(stable_cnt+1, DEBOUNCE_SCANS)`; else `stable_cnt <= 0`.
  - `prev <= snapshot`.
  - When the new `stable_cnt` equals DEBOUNCE_SCANS, `key_map <= snapshot`. A press is therefore accepted after DEBOUNCE_SCANS+1 identical scans.
- Event FSM, evaluated on `key_map`:
  - RELEASED: `key_map != 0` → PRESSED. `key_code <=` index of the lowest set bit. Pulse `key_valid` for 1 cycle. Set `key_down` = 1.
  - PRESSED: `key_map == 0` → RELEASED. Set `key_down` = 0. No pulse.
  - PRESSED, `key_map` changes but remains nonzero (key added or swapped): stay in PRESSED. No pulse. `key_code` is held.
- Multiple simultaneous keys: priority goes to the lowest index.

## Timing

- Reset values:
  - `row` = 4'b1110.
  - `key_map`, `key_code`, `key_valid`, `key_down` = 0.
  - `cnt`, `row_idx`, snapshot, `prev`, `stable_cnt` = 0.
  - FSM = RELEASED.
- Reset asserted mid-press clears everything within the same edge. A key still held after reset must re-debounce and produces a fresh `key_valid`.
- Full scan period: 4·SCAN_TIME cycles (4 ms by default).
- Latency: `key_map` updates on the completion edge. `key_valid`, `key_code`, and `key_down` update 1 cycle later (registered FSM).
- `key_valid` is never high on two consecutive cycles.
- Counter wrap and scan completion coincide on the same edge; the row 3 sample is included in that completion's comparison.

## Test plan

Bench uses SCAN_TIME=8 and DEBOUNCE_SCANS=2. The keypad model drives `col[c]=0` iff the modelled key (active row, c) is pressed.

- **Reset:** hold `rst` for 3 cycles → `row`=1110 and all outputs 0. After release, `row` steps to 1101 8 cycles later, then 1011, then 0111, then 1110.
- **Single press:** hold key 6 (r1, c2) stable from before a scan start → after 3 identical scans `key_map`=16'h0040. Next cycle, `key_valid`=1 for exactly 1 cycle, `key_code`=6, `key_down`=1.
- **Release:** release key 6 → after 3 scans `key_map`=0 and `key_down`=0; no `key_valid`.
- **Bounce:** toggle key 9 every scan for 10 scans, then hold it → no `key_valid` during the toggling. Exactly one pulse afterwards, with `key_code`=9.
- **Multi-key:** press keys 3 and 12 together → `key_map`=16'h1008, `key_code`=3, one pulse. Then add key 0 while both are held → `key_map`=16'h1009, no pulse, `key_code` stays 3.
- **Reset mid-press:** assert `rst` while key 5 is held and `key_down`=1 → outputs clear. After release, with key 5 still held, a new `key_valid` with `key_code`=5 follows after 3 scans.
